// File: rtl/slider_pkg.sv
// Shared constants and types for the 2x4 slider-puzzle board and its move controllers.
// Cell index layout: bit 2 = row, bits 1:0 = column.
package slider_pkg;

    localparam int unsigned CELL_W    = 3;
    localparam int unsigned NUM_CELLS = 8;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef logic [CELL_W-1:0] cell_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_t;

endpackage

// File: rtl/slider_move_sequencer_if.sv
// Command, board and status signals between the move sequencer and its requesters/board.
// master = command side (requesters, sync source); slave = the sequencer.
interface slider_move_sequencer_if
    import slider_pkg::*;
#(
    parameter int unsigned MOVE_CNT_W = 16
);

    logic                  req0_valid;
    logic [1:0]            req0_dir;
    logic                  req0_ack;
    logic                  req0_nack;
    logic                  req1_valid;
    logic [1:0]            req1_dir;
    logic                  req1_ack;
    logic                  req1_nack;
    logic                  sync_valid;
    cell_t                 sync_pos;
    cell_t                 board_from;
    cell_t                 board_to;
    logic                  busy;
    cell_t                 blank_pos;
    logic [MOVE_CNT_W-1:0] move_count;

    modport master (
        output req0_valid, req0_dir, req1_valid, req1_dir, sync_valid, sync_pos,
        input  req0_ack, req0_nack, req1_ack, req1_nack,
        input  board_from, board_to, busy, blank_pos, move_count
    );

    modport slave (
        input  req0_valid, req0_dir, req1_valid, req1_dir, sync_valid, sync_pos,
        output req0_ack, req0_nack, req1_ack, req1_nack,
        output board_from, board_to, busy, blank_pos, move_count
    );

endinterface

// File: rtl/slider_neighbour.sv
// Combinational neighbour lookup: blank cell + direction -> cell that would slide in,
// plus a legal flag that is low when the move leaves the 2x4 board.
module slider_neighbour
    import slider_pkg::*;
(
    input  cell_t      blank_i,
    input  logic [1:0] dir_i,
    output cell_t      neighbour_o,
    output logic       legal_o
);

    always_comb begin
        neighbour_o = blank_i;
        legal_o     = 1'b0;
        unique case (dir_i)
            DIR_UP: begin
                if (blank_i[2]) begin
                    neighbour_o = blank_i - cell_t'(4);
                    legal_o     = 1'b1;
                end
            end
            DIR_DOWN: begin
                if (!blank_i[2]) begin
                    neighbour_o = blank_i + cell_t'(4);
                    legal_o     = 1'b1;
                end
            end
            DIR_LEFT: begin
                if (blank_i[1:0] != 2'd0) begin
                    neighbour_o = blank_i - cell_t'(1);
                    legal_o     = 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (blank_i[1:0] != 2'd3) begin
                    neighbour_o = blank_i + cell_t'(1);
                    legal_o     = 1'b1;
                end
            end
            default: begin
                neighbour_o = blank_i;
                legal_o     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/slider_move_sequencer.sv
// Round-robin move sequencer for the 2x4 slider board: arbitrates two direction requesters,
// range-checks against the tracked blank, and issues one from/to pair per legal move.
module slider_move_sequencer
    import slider_pkg::*;
#(
    parameter int unsigned MOVE_CNT_W = 16,
    parameter int unsigned INIT_BLANK = 0
) (
    input logic                      clock,
    input logic                      reset_n,
    slider_move_sequencer_if.slave   bus
);

    localparam cell_t InitBlank = cell_t'(INIT_BLANK);
    localparam logic [MOVE_CNT_W-1:0] CntOne = {{(MOVE_CNT_W-1){1'b0}}, 1'b1};

    state_t                state_q;
    logic                  rr_last_q;
    cell_t                 blank_q;
    cell_t                 from_q;
    cell_t                 to_q;
    logic [MOVE_CNT_W-1:0] count_q;
    logic                  busy_q;
    logic                  ack0_q;
    logic                  nack0_q;
    logic                  ack1_q;
    logic                  nack1_q;

    logic       elig0;
    logic       elig1;
    logic       any_req;
    logic       gnt;
    logic [1:0] gnt_dir;
    cell_t      nb_cell;
    logic       nb_legal;

    // A requester whose nack is on the wire this cycle has not yet seen it, so its still-high
    // valid is the old command; masking it avoids a duplicate nack.
    always_comb begin
        elig0   = bus.req0_valid & ~nack0_q;
        elig1   = bus.req1_valid & ~nack1_q;
        any_req = elig0 | elig1;
        gnt     = (elig0 & elig1) ? ~rr_last_q : elig1;
        gnt_dir = gnt ? bus.req1_dir : bus.req0_dir;
    end

    slider_neighbour u_neighbour (
        .blank_i     (blank_q),
        .dir_i       (gnt_dir),
        .neighbour_o (nb_cell),
        .legal_o     (nb_legal)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b1;
            blank_q   <= InitBlank;
            from_q    <= InitBlank;
            to_q      <= InitBlank;
            count_q   <= '0;
            busy_q    <= 1'b0;
            ack0_q    <= 1'b0;
            nack0_q   <= 1'b0;
            ack1_q    <= 1'b0;
            nack1_q   <= 1'b0;
        end else begin
            ack0_q  <= 1'b0;
            nack0_q <= 1'b0;
            ack1_q  <= 1'b0;
            nack1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.sync_valid) begin
                        blank_q <= bus.sync_pos;
                        from_q  <= bus.sync_pos;
                        to_q    <= bus.sync_pos;
                    end else if (any_req) begin
                        rr_last_q <= gnt;
                        if (nb_legal) begin
                            from_q  <= nb_cell;
                            to_q    <= blank_q;
                            ack0_q  <= ~gnt;
                            ack1_q  <= gnt;
                            busy_q  <= 1'b1;
                            state_q <= StIssue;
                        end else begin
                            nack0_q <= ~gnt;
                            nack1_q <= gnt;
                        end
                    end
                end
                StIssue: begin
                    // The sliding tile's cell becomes the new blank; from==to parks the board.
                    blank_q <= from_q;
                    to_q    <= from_q;
                    count_q <= count_q + CntOne;
                    state_q <= StWait;
                end
                StWait: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.req0_ack   = ack0_q;
    assign bus.req0_nack  = nack0_q;
    assign bus.req1_ack   = ack1_q;
    assign bus.req1_nack  = nack1_q;
    assign bus.board_from = from_q;
    assign bus.board_to   = to_q;
    assign bus.busy       = busy_q;
    assign bus.blank_pos  = blank_q;
    assign bus.move_count = count_q;

endmodule

// File: tb/tb_slider_move_sequencer.sv
// Scoreboard bench for slider_move_sequencer: a board-level reference model predicts every
// ack/nack and the resulting blank/count; a negedge monitor compares against the DUT.
module tb_slider_move_sequencer;
    import slider_pkg::*;

    localparam int unsigned CW   = 3;
    localparam int          INIT = 0;

    typedef struct {
        int who;
        bit ack;
        int from;
        int to;
    } exp_t;

    logic       clock;
    logic       reset_n;
    logic       req_valid [2];
    logic [1:0] req_dir   [2];
    logic       sync_v;
    logic [2:0] sync_p;

    int checks;
    int errors;
    int cyc;

    exp_t exp_q[$];
    int   m_blank;
    int   m_cnt;
    int   m_last;
    int   m_cool;
    int   m_nack_who;
    int   m_prev_nack;
    bit   rst_edge;

    slider_move_sequencer_if #(.MOVE_CNT_W(CW)) bus ();

    assign bus.req0_valid = req_valid[0];
    assign bus.req0_dir   = req_dir[0];
    assign bus.req1_valid = req_valid[1];
    assign bus.req1_dir   = req_dir[1];
    assign bus.sync_valid = sync_v;
    assign bus.sync_pos   = sync_p;

    slider_move_sequencer #(.MOVE_CNT_W(CW), .INIT_BLANK(INIT)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Board rules in row/column terms.
    function automatic bit model_move(input int b, input int dir, output int nb);
        int r;
        int c;
        r  = b / 4;
        c  = b % 4;
        nb = b;
        case (dir)
            0: if (r == 1) begin nb = b - 4; return 1'b1; end
            1: if (r == 0) begin nb = b + 4; return 1'b1; end
            2: if (c != 0) begin nb = b - 1; return 1'b1; end
            default: if (c != 3) begin nb = b + 1; return 1'b1; end
        endcase
        return 1'b0;
    endfunction

    // Reference model: a legal move makes the sequencer unavailable for two further cycles.
    always @(posedge clock) begin
        rst_edge = !reset_n;
        if (!reset_n) begin
            m_blank    = INIT;
            m_cnt      = 0;
            m_last     = 1;
            m_cool     = 0;
            m_nack_who = -1;
            exp_q.delete();
        end else begin
            m_prev_nack = m_nack_who;
            m_nack_who  = -1;
            if (m_cool > 0) begin
                m_cool--;
            end else if (sync_v) begin
                m_blank = int'(sync_p);
            end else begin
                bit e0;
                bit e1;
                int who;
                int nb;
                exp_t e;
                e0 = req_valid[0] && (m_prev_nack != 0);
                e1 = req_valid[1] && (m_prev_nack != 1);
                if (e0 || e1) begin
                    who    = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
                    m_last = who;
                    e.who  = who;
                    if (model_move(m_blank, int'(req_dir[who]), nb)) begin
                        e.ack   = 1'b1;
                        e.from  = nb;
                        e.to    = m_blank;
                        m_blank = nb;
                        m_cnt   = (m_cnt + 1) % (1 << CW);
                        m_cool  = 2;
                    end else begin
                        e.ack      = 1'b0;
                        e.from     = m_blank;
                        e.to       = m_blank;
                        m_nack_who = who;
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: every response pulse pops one expectation; idle cycles check tracked state.
    always @(negedge clock) begin
        logic [3:0] act;
        logic [3:0] expc;
        exp_t e;
        act = {bus.req0_ack, bus.req0_nack, bus.req1_ack, bus.req1_nack};
        if (rst_edge) begin
            chk("reset_blank", int'(bus.blank_pos), INIT);
            chk("reset_count", int'(bus.move_count), 0);
            chk("reset_busy", int'(bus.busy), 0);
            chk("reset_pulses", int'(act), 0);
            chk("reset_from", int'(bus.board_from), INIT);
            chk("reset_to", int'(bus.board_to), INIT);
        end else begin
            if (act != 4'b0000 || exp_q.size() != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", int'(act), 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ack) expc = (e.who == 1) ? 4'b0010 : 4'b1000;
                    else       expc = (e.who == 1) ? 4'b0001 : 4'b0100;
                    chk("pulse_ack0_nack0_ack1_nack1", int'(act), int'(expc));
                    if (e.ack) begin
                        chk("issue_from", int'(bus.board_from), e.from);
                        chk("issue_to", int'(bus.board_to), e.to);
                    end
                end
            end
            chk("busy", int'(bus.busy), (m_cool != 0) ? 1 : 0);
            if (m_cool == 0) begin
                chk("idle_blank", int'(bus.blank_pos), m_blank);
                chk("idle_count", int'(bus.move_count), m_cnt);
                chk("idle_from", int'(bus.board_from), m_blank);
                chk("idle_to", int'(bus.board_to), m_blank);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic do_sync(input int pos);
        sync_v = 1'b1;
        sync_p = 3'(pos);
        tick();
        sync_v = 1'b0;
    endtask

    function automatic bit pulse_of(input int k);
        return (k == 1) ? (bus.req1_ack | bus.req1_nack) : (bus.req0_ack | bus.req0_nack);
    endfunction

    // Requester: hold valid until answered, drop it on the following cycle.
    task automatic agent(input int k, input int n);
        bit got;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            req_dir[k]   = 2'($urandom_range(0, 3));
            req_valid[k] = 1'b1;
            got          = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                tick();
                got = pulse_of(k);
            end
            if (!got) chk("agent_timeout", 0, 1);
            tick();
            req_valid[k] = 1'b0;
        end
    endtask

    task automatic sync_agent(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if ($urandom_range(0, 15) == 0) begin
                sync_v = 1'b1;
                sync_p = 3'($urandom_range(0, 7));
            end else begin
                sync_v = 1'b0;
            end
        end
        sync_v = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int last_ack;
        int got_ack;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        reset_n      = 1'b0;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_dir[0]   = 2'd0;
        req_dir[1]   = 2'd0;
        sync_v       = 1'b0;
        sync_p       = 3'd0;
        do_reset();

        // Blank 0, move down: tile at 4 slides into 0.
        req_valid[0] = 1'b1;
        req_dir[0]   = DIR_DOWN;
        tick();
        chk("d1_ack0", int'(bus.req0_ack), 1);
        chk("d1_from", int'(bus.board_from), 4);
        chk("d1_to", int'(bus.board_to), 0);
        req_valid[0] = 1'b0;
        tick();
        chk("d1_blank", int'(bus.blank_pos), 4);
        chk("d1_count", int'(bus.move_count), 1);
        tick();
        chk("d1_park_from", int'(bus.board_from), 4);
        chk("d1_park_to", int'(bus.board_to), 4);

        // Blank 0, up is off-board.
        do_sync(0);
        req_valid[1] = 1'b1;
        req_dir[1]   = DIR_UP;
        tick();
        chk("d2_nack1", int'(bus.req1_nack), 1);
        chk("d2_ack1", int'(bus.req1_ack), 0);
        chk("d2_from", int'(bus.board_from), 0);
        chk("d2_count", int'(bus.move_count), 1);
        tick();
        req_valid[1] = 1'b0;
        tick();

        // Both requesters after reset from blank 5: req0 first, then alternation.
        do_reset();
        do_sync(5);
        req_valid[0] = 1'b1;
        req_dir[0]   = DIR_LEFT;
        req_valid[1] = 1'b1;
        req_dir[1]   = DIR_RIGHT;
        tick();
        chk("d3_first_ack0", int'(bus.req0_ack), 1);
        chk("d3_first_from", int'(bus.board_from), 4);
        chk("d3_first_to", int'(bus.board_to), 5);
        repeat (3) tick();
        chk("d3_second_ack1", int'(bus.req1_ack), 1);
        chk("d3_second_from", int'(bus.board_from), 5);
        chk("d3_second_to", int'(bus.board_to), 4);
        repeat (6) tick();
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        repeat (3) tick();

        // One requester back-to-back: acks exactly 3 cycles apart.
        do_reset();
        req_valid[0] = 1'b1;
        req_dir[0]   = DIR_RIGHT;
        last_ack     = -1;
        for (int m = 0; m < 4; m++) begin
            got_ack = 0;
            for (int c = 0; c < 10 && got_ack == 0; c++) begin
                tick();
                if (bus.req0_ack) got_ack = 1;
            end
            chk("d4_ack_seen", got_ack, 1);
            if (last_ack >= 0) chk("d4_ack_spacing", cyc - last_ack, 3);
            last_ack   = cyc;
            req_dir[0] = (req_dir[0] == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        end
        req_valid[0] = 1'b0;
        repeat (3) tick();

        // Sync wins over a same-cycle request; the request is then judged at blank 7.
        sync_v       = 1'b1;
        sync_p       = 3'd7;
        req_valid[0] = 1'b1;
        req_dir[0]   = DIR_RIGHT;
        tick();
        sync_v = 1'b0;
        chk("d5_blank", int'(bus.blank_pos), 7);
        chk("d5_no_ack", int'(bus.req0_ack | bus.req0_nack), 0);
        tick();
        chk("d5_nack0", int'(bus.req0_nack), 1);
        tick();
        req_valid[0] = 1'b0;
        tick();

        // Reset during ISSUE aborts the move.
        do_sync(2);
        req_valid[0] = 1'b1;
        req_dir[0]   = DIR_DOWN;
        tick();
        chk("d6_in_issue", int'(bus.busy), 1);
        req_valid[0] = 1'b0;
        reset_n      = 1'b0;
        tick();
        chk("d6_blank", int'(bus.blank_pos), INIT);
        chk("d6_count", int'(bus.move_count), 0);
        chk("d6_ack", int'(bus.req0_ack), 0);
        chk("d6_busy", int'(bus.busy), 0);
        reset_n = 1'b1;
        tick();

        // Randomized traffic; the 3-bit counter wraps many times.
        fork
            agent(0, 60);
            agent(1, 60);
            sync_agent(400);
        join
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/slider_move_sequencer.md
Name: slider_move_sequencer

Overview:
- Controller for the 2x4 slider-puzzle board register file. The board latches 3-bit from/to cell indices on every clock edge and applies the move one edge later.
- Two requesters issue direction commands for the blank cell. This block arbitrates between them round-robin, range-checks each move against the tracked blank position, and drives the board's from/to inputs for exactly one cycle per legal move.
- Keeps the blank position and a move counter. Sits between the board and the command sources (user port, scramble engine).

Parameters:
- MOVE_CNT_W, 16, width of the move counter; wraps modulo 2^MOVE_CNT_W.
- INIT_BLANK, 0, blank cell index loaded at reset (0..7).

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a command; held high until ack or nack.
- req0_dir  in  2  blank moves: 0=up, 1=down, 2=left, 3=right.
- req0_ack  out  1  one-cycle pulse: move accepted and issued.
- req0_nack  out  1  one-cycle pulse: move rejected (off-board).
- req1_valid, req1_dir, req1_ack, req1_nack  same as requester 0.
- sync_valid  in  1  force-load the blank position (e.g. after board re-init).
- sync_pos  in  3  blank index for sync_valid.
- board_from  out  3  source cell to board (tile that slides).
- board_to  out  3  destination cell to board (current blank).
- busy  out  1  high in ISSUE and WAIT.
- blank_pos  out  3  tracked blank index.
- move_count  out  MOVE_CNT_W  number of issued moves.

Behaviour:
- Cell index = {row, col[1:0]}: row = bit 2, col = bits 1:0.
- Neighbour of blank b: up needs row=1 (b-4); down needs row=0 (b+4); left needs col≠0 (b-1); right needs col≠3 (b+1). Otherwise the move is illegal.
- Reset (reset_n=0 at an edge):
  - state=IDLE, blank_pos=INIT_BLANK, move_count=0, rr_last=1 (req0 wins first tie).
  - All ack/nack=0, busy=0, board_from=board_to=INIT_BLANK.
  - Reset mid-ISSUE or mid-WAIT aborts with no ack; the board may already have latched the move, and software must resync via sync_valid.
- All outputs are registered.
- IDLE:
  - board_from=board_to=blank_pos. from==to is never a valid board move, so this is a no-op.
  - sync_valid has priority. blank_pos<=sync_pos; requests are ignored that cycle.
  - Otherwise, if any req valid, grant: with one requester, that one; with both, the one ≠ rr_last. Then rr_last<=grant.
  - Illegal direction: pulse nack of the granted requester on the next cycle; stay IDLE; board outputs unchanged.
  - Legal direction: board_to<=blank_pos, board_from<=neighbour, ack of the granted requester pulses next cycle, state<=ISSUE.
- ISSUE (1 cycle):
  - from/to presented to the board; ack high; busy=1.
  - At exit: blank_pos<=board_from, move_count<=move_count+1, board_from<=board_from and board_to<=board_from (idle-no-op pattern at the new blank), state<=WAIT.
- WAIT (1 cycle): board applies the move; busy=1; then state<=IDLE.
- Throughput: one legal move per 3 cycles. A grant in cycle t gives ack in t+1, the board update at the end of t+2, and a new grant possible in t+3.
- sync_valid in ISSUE or WAIT is ignored. The requester keeps valid until its ack/nack; valid deasserting earlier is allowed and drops the request.
- ack and nack never pulse in the same cycle; at most one requester is acked or nacked per cycle.
- move_count wraps from all-ones to 0.

Decomposition:
- Shared package slider_pkg: constants DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3; CELL_W=3; NUM_CELLS=8; state encoding IDLE/ISSUE/WAIT.
- One sub-module, slider_neighbour (combinational): blank index + dir -> neighbour index + legal flag. It is reused by the scramble engine.
- Arbiter stays inline.

Test Plan:
- Reset with INIT_BLANK=0; req0 dir=down -> ack0 one cycle later; board_to=0, board_from=4 for one cycle; blank_pos=4; move_count=1; board_from=board_to=4 afterwards.
- blank=0; req1 dir=up -> nack1 pulse; no ack; board outputs stay 0/0; move_count unchanged.
- blank=5; req0 and req1 both valid (left, right) after reset -> req0 granted first (from=4, to=5); req1 granted next (blank 4, right: from=5, to=4); grants alternate while both are held.
- Back-to-back legal moves from one requester -> successive acks exactly 3 cycles apart; busy high for 2 of every 3 cycles.
- sync_valid=1, sync_pos=7 in the same IDLE cycle as req0 dir=right -> blank_pos=7, no grant; next cycle req0 right is nacked (col=3).
- reset_n low during ISSUE -> next cycle state IDLE, blank_pos=INIT_BLANK, move_count=0, no pending ack; MOVE_CNT_W=2 with 5 moves -> move_count=1.
